// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch front end: PC generator feeding a DEPTH-entry prefetch
// queue of {instruction, PC, PC+4}. Redirects from EX flush the queue.
module fetch_prefetch_unit #(
    parameter int unsigned       XLEN      = 32,
    parameter int unsigned       ILEN      = 32,
    parameter int unsigned       DEPTH     = 4,
    parameter logic [XLEN-1:0]   RESET_PC  = '0,
    parameter logic [ILEN-1:0]   NOP_INSTR = 32'h00000013
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic [XLEN-1:0]           imem_addr,
    output logic                      imem_req,
    input  logic [ILEN-1:0]           imem_rdata,
    input  logic                      imem_ready,
    input  logic                      redirect_valid,
    input  logic [XLEN-1:0]           redirect_pc,
    input  logic                      stall_d,
    output logic                      valid_d,
    output logic [ILEN-1:0]           instr_d,
    output logic [XLEN-1:0]           pc_d,
    output logic [XLEN-1:0]           pcplus4_d,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int unsigned PTRW = $clog2(DEPTH);
    localparam int unsigned CW   = PTRW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [XLEN-1:0] fetchPc;
    logic [XLEN-1:0] fetchPcPlus4;
    logic [PTRW-1:0] wrPtr;
    logic [PTRW-1:0] rdPtr;
    logic [CW-1:0]   cnt;
    logic            push;
    logic            pop;
    logic            unusedRedirectLow;

    logic [ILEN-1:0] instrQ [DEPTH];
    logic [XLEN-1:0] pcQ    [DEPTH];
    logic [XLEN-1:0] pc4Q   [DEPTH];

    // Redirect target is word-aligned; the two low bits are dropped.
    assign unusedRedirectLow = &redirect_pc[1:0];

    // Handshake and queue control decoded from current occupancy.
    always_comb begin
        fetchPcPlus4 = fetchPc + XLEN'(4);
        valid_d      = (cnt != '0);
        pop          = valid_d & ~stall_d & ~redirect_valid;
        imem_req     = ~redirect_valid & ((cnt < DEPTH_C) | pop);
        push         = imem_req & imem_ready;
        imem_addr    = fetchPc;
        count        = cnt;
    end

    // Head outputs read directly from storage; idle values when empty.
    always_comb begin
        instr_d   = NOP_INSTR;
        pc_d      = '0;
        pcplus4_d = '0;
        if (valid_d) begin
            instr_d   = instrQ[rdPtr];
            pc_d      = pcQ[rdPtr];
            pcplus4_d = pc4Q[rdPtr];
        end
    end

    // PC, pointers and occupancy; reset beats redirect beats push/pop.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fetchPc <= RESET_PC;
            wrPtr   <= '0;
            rdPtr   <= '0;
            cnt     <= '0;
        end else if (redirect_valid) begin
            fetchPc <= {redirect_pc[XLEN-1:2], 2'b00};
            wrPtr   <= '0;
            rdPtr   <= '0;
            cnt     <= '0;
        end else begin
            if (push) begin
                wrPtr   <= wrPtr + PTRW'(1);
                fetchPc <= fetchPcPlus4;
            end
            if (pop) begin
                rdPtr <= rdPtr + PTRW'(1);
            end
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end

    // Queue storage; contents need no reset since the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            instrQ[wrPtr] <= imem_rdata;
            pcQ[wrPtr]    <= fetchPc;
            pc4Q[wrPtr]   <= fetchPcPlus4;
        end
    end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed self-checking bench for fetch_prefetch_unit (DEPTH=4, RESET_PC=0).
module tb_fetch_prefetch_unit;

    localparam logic [31:0] NOP = 32'h00000013;
    localparam logic [31:0] KEY = 32'h5A5A0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall_d;
    logic        valid_d;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pcplus4_d;
    logic [2:0]  count;

    int nCompared   = 0;
    int nMismatched = 0;

    fetch_prefetch_unit #(
        .XLEN(32), .ILEN(32), .DEPTH(4), .RESET_PC(32'h0), .NOP_INSTR(NOP)
    ) dut (
        .clk(clk), .rst(rst),
        .imem_addr(imem_addr), .imem_req(imem_req),
        .imem_rdata(imem_rdata), .imem_ready(imem_ready),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .stall_d(stall_d), .valid_d(valid_d), .instr_d(instr_d),
        .pc_d(pc_d), .pcplus4_d(pcplus4_d), .count(count)
    );

    always #5 clk = ~clk;

    // Memory model: each word is a recognisable function of its address.
    assign imem_rdata = imem_addr ^ KEY;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic checkHead(input string tag, input logic v, input logic [31:0] pc);
        checkVal({tag, ".valid"}, 32'(valid_d), 32'(v));
        checkVal({tag, ".pc"},    pc_d,      v ? pc : 32'h0);
        checkVal({tag, ".pc4"},   pcplus4_d, v ? pc + 32'd4 : 32'h0);
        checkVal({tag, ".instr"}, instr_d,   v ? (pc ^ KEY) : NOP);
    endtask

    task automatic setIn(input logic r, input logic rv, input logic [31:0] rpc,
                         input logic st, input logic rdy);
        rst = r; redirect_valid = rv; redirect_pc = rpc; stall_d = st; imem_ready = rdy;
    endtask

    task automatic sample;
        @(negedge clk);
    endtask

    task automatic advance;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset, two cycles
        setIn(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        advance();
        sample();
        checkVal("rst.count", 32'(count), 32'd0);
        checkVal("rst.addr", imem_addr, 32'h0);
        checkHead("rst", 1'b0, 32'h0);
        advance();

        // Streaming fetch with no stalls
        for (int k = 0; k < 5; k++) begin
            setIn(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
            sample();
            checkVal("stream.addr", imem_addr, 32'(4 * k));
            checkVal("stream.req", 32'(imem_req), 32'd1);
            checkVal("stream.count", 32'(count), (k == 0) ? 32'd0 : 32'd1);
            checkHead("stream", k != 0, 32'(4 * (k - 1)));
            advance();
        end

        // Fill to full under decode stall
        setIn(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        advance();
        for (int k = 0; k < 10; k++) begin
            setIn(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
            sample();
            checkVal("fill.count", 32'(count), (k < 4) ? 32'(k) : 32'd4);
            checkVal("fill.addr", imem_addr, (k < 4) ? 32'(4 * k) : 32'd16);
            checkVal("fill.req", 32'(imem_req), (k < 4) ? 32'd1 : 32'd0);
            checkHead("fill", k != 0, 32'h0);
            advance();
        end

        // Full-queue pass-through: in-order drain while fetch continues
        for (int j = 0; j < 8; j++) begin
            setIn(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
            sample();
            checkVal("pass.count", 32'(count), 32'd4);
            checkVal("pass.req", 32'(imem_req), 32'd1);
            checkVal("pass.addr", imem_addr, 32'(16 + 4 * j));
            checkHead("pass", 1'b1, 32'(4 * j));
            advance();
        end

        // One pop without a push brings occupancy to 3
        setIn(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        sample();
        checkVal("drop.addr", imem_addr, 32'd48);
        checkHead("drop", 1'b1, 32'd32);
        advance();

        // Redirect to a misaligned target with three entries queued
        setIn(1'b1, 1'b1, 32'h103, 1'b0, 1'b1);
        sample();
        checkVal("redir.count", 32'(count), 32'd3);
        checkVal("redir.req", 32'(imem_req), 32'd0);
        advance();
        setIn(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        sample();
        checkVal("redir1.count", 32'(count), 32'd0);
        checkVal("redir1.addr", imem_addr, 32'h100);
        checkHead("redir1", 1'b0, 32'h0);
        advance();
        sample();
        checkVal("redir2.count", 32'(count), 32'd1);
        checkHead("redir2", 1'b1, 32'h100);
        advance();

        // Redirect together with stall, then three wait states at 0x20
        setIn(1'b1, 1'b1, 32'h20, 1'b1, 1'b1);
        advance();
        for (int k = 0; k < 3; k++) begin
            setIn(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
            sample();
            checkVal("wait.addr", imem_addr, 32'h20);
            checkVal("wait.req", 32'(imem_req), 32'd1);
            checkVal("wait.count", 32'(count), 32'd0);
            advance();
        end
        setIn(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        sample();
        checkVal("ready.addr", imem_addr, 32'h20);
        advance();
        setIn(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        sample();
        checkVal("ready.count", 32'(count), 32'd1);
        checkVal("ready.addr2", imem_addr, 32'h24);
        checkHead("ready", 1'b1, 32'h20);
        advance();

        // Second entry, then reset during a wait state
        setIn(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        advance();
        setIn(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        sample();
        checkVal("midrst.count0", 32'(count), 32'd2);
        checkVal("midrst.addr0", imem_addr, 32'h28);
        advance();
        setIn(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        sample();
        checkVal("midrst.count", 32'(count), 32'd0);
        checkVal("midrst.addr", imem_addr, 32'h0);
        checkHead("midrst", 1'b0, 32'h0);
        advance();

        // Address wrap at the top of the address space
        setIn(1'b1, 1'b1, 32'hFFFFFFFE, 1'b1, 1'b1);
        advance();
        setIn(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        sample();
        checkVal("wrap.addr0", imem_addr, 32'hFFFFFFFC);
        advance();
        setIn(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        sample();
        checkVal("wrap.addr", imem_addr, 32'h0);
        checkVal("wrap.count", 32'(count), 32'd1);
        checkVal("wrap.pc", pc_d, 32'hFFFFFFFC);
        checkVal("wrap.pc4", pcplus4_d, 32'h0);
        checkVal("wrap.instr", instr_d, 32'hFFFFFFFC ^ KEY);
        advance();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/fetch_prefetch_unit.md
Name: fetch_prefetch_unit

Overview:
Parametrised instruction-fetch front end for the pipelined RISC-V core. It replaces the single PC register plus IF/ID register pair with a PC generator that feeds a DEPTH-entry prefetch queue of {instruction, PC, PC+4}. The queue decouples instruction-memory wait states from decode stalls. Taken branches and jumps resolved in EX redirect the PC and flush the whole queue in one cycle.

Parameters:
XLEN, 32, width of PC and address paths
ILEN, 32, instruction width
DEPTH, 4, prefetch queue entries; power of 2, minimum 2
RESET_PC, 0, fetch address after reset
NOP_INSTR, 32'h00000013, value driven on instr_d when the queue is empty (addi x0,x0,0)

Ports:
clk  in  1  clock, all state updates on the rising edge
rst  in  1  synchronous reset, active-low; state resets on a rising edge of clk while rst=0
imem_addr  out  XLEN  fetch address, equal to fetch_pc
imem_req  out  1  fetch request this cycle
imem_rdata  in  ILEN  instruction word, valid in the same cycle when imem_ready=1
imem_ready  in  1  memory accepts the request and returns imem_rdata this cycle
redirect_valid  in  1  taken branch/jump/jalr from EX
redirect_pc  in  XLEN  target address (PCTargetE or ALUResultE)
stall_d  in  1  decode cannot accept the head entry
valid_d  out  1  head entry is valid
instr_d  out  ILEN  head instruction; NOP_INSTR when valid_d=0
pc_d  out  XLEN  head PC; 0 when valid_d=0
pcplus4_d  out  XLEN  head PC+4; 0 when valid_d=0
count  out  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset (rst=0 at an edge): fetch_pc=RESET_PC, read and write pointers=0, count=0. After reset, valid_d=0, instr_d=NOP_INSTR, pc_d=0, pcplus4_d=0. rst has priority over every other input.
- pop = valid_d & ~stall_d & ~redirect_valid.
- imem_req = ~redirect_valid & ((count<DEPTH) | pop). Full-queue pass-through is allowed: push and pop happen in the same cycle.
- push = imem_req & imem_ready.
- On push: write {imem_rdata, fetch_pc, fetch_pc+4} at the write pointer, advance the write pointer, and set fetch_pc to fetch_pc+4. All sums are modulo 2^XLEN, so 0xFFFFFFFC+4 wraps to 0.
- On pop: advance the read pointer.
- count next value = count + push - pop. Pointers wrap modulo DEPTH.
- imem_req=1 with imem_ready=0 is a wait state: fetch_pc holds and nothing is pushed. imem_addr must stay stable until imem_ready=1 or a redirect occurs.
- Redirect (redirect_valid=1): the queue flushes at the edge, so pointers=0 and count=0. fetch_pc = {redirect_pc[XLEN-1:2], 2'b00}; low bits are ignored. No push or pop occurs that cycle, and a response arriving that cycle is discarded. valid_d=0 in the following cycle.
- Fetch-to-decode latency: an instruction pushed in cycle N appears on the outputs in cycle N+1 if the queue was empty. Minimum redirect penalty is 2 cycles (redirect cycle plus refill cycle).
- Head outputs come straight from queue storage indexed by the read pointer. There is no extra register stage.
- Empty with stall_d=1: valid_d stays 0 and outputs hold the NOP/zero values.
- Full with stall_d=1: imem_req=0 and fetch_pc holds.
- redirect_valid together with stall_d=1: the redirect wins and the queue flushes.

Test Plan:
1. Reset with rst=0 for 2 cycles, then imem_ready=1 constantly and stall_d=0 -> imem_addr 0,4,8,... on consecutive cycles; valid_d rises 1 cycle after release; pc_d follows 0,4,8 with pcplus4_d=pc_d+4.
2. stall_d=1 for 10 cycles, DEPTH=4, imem_ready=1 -> count reaches 4 after 4 pushes; imem_req=0 afterwards; fetch_pc=16; head stays pc_d=0. On release, entries drain in order 0,4,8,12 while fetching continues from 16.
3. Full queue, stall_d=0, imem_ready=1 -> one push and one pop per cycle; count stays 4; no entry is lost or duplicated (scoreboard compares pc_d sequence).
4. redirect_valid=1 with redirect_pc=0x103 while count=3 -> next cycle count=0, valid_d=0, instr_d=0x00000013, imem_addr=0x100. The cycle after that gives valid_d=1 and pc_d=0x100.
5. imem_ready held at 0 for 3 cycles at fetch_pc=0x20 -> imem_addr stays 0x20 and count is unchanged. Ready rising pushes exactly one entry with pc=0x20.
6. rst=0 asserted mid-stream with count=2 and a pending wait state -> next cycle count=0, valid_d=0, fetch_pc=RESET_PC. Also with fetch_pc=0xFFFFFFFC -> a push wraps fetch_pc to 0 and pcplus4_d=0.
